// File: rtl/acs_bank.sv
// acs_bank: add-compare-select bank for a radix-2 Viterbi trellis with 2^(K-1) states.
// Define ACS_BANK_BEST_STATE_EN to add the registered lowest-metric state output.
module acs_bank #(
  parameter int K    = 3,
  parameter int BM_W = 2,
  parameter int PM_W = 8,
  localparam int N   = 32'd1 << (K - 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic                start,
  input  logic [N*2*BM_W-1:0] bm,
  output logic                out_valid,
  output logic [N-1:0]        decision,
  output logic [N-1:0]        state_valid,
  output logic [N*PM_W-1:0]   path_metric
`ifdef ACS_BANK_BEST_STATE_EN
  ,
  output logic [K-2:0]        best_state
`endif
);

  localparam logic [PM_W-1:0] PM_MAX  = {PM_W{1'b1}};
  localparam logic [PM_W-1:0] PM_HALF = {1'b1, {(PM_W-1){1'b0}}};

  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] pm,
                                               input logic [BM_W-1:0] br);
    logic [PM_W:0] sum;
    sum = {1'b0, pm} + {{(PM_W+1-BM_W){1'b0}}, br};
    if (sum[PM_W]) begin
      return PM_MAX;
    end else begin
      return sum[PM_W-1:0];
    end
  endfunction

  logic [PM_W-1:0]   cur_pm_s [N];
  logic [N-1:0]      cur_sv_s;
  logic [PM_W-1:0]   c0_s [N];
  logic [PM_W-1:0]   c1_s [N];
  logic [PM_W-1:0]   raw_pm_s [N];
  logic [N-1:0]      new_sv_s;
  logic [N-1:0]      dec_s;
  logic [PM_W-1:0]   min_pm_s;
  logic              found_s;
  logic              take_s;
  logic              norm_s;
  logic [N*PM_W-1:0] next_pm_s;
`ifdef ACS_BANK_BEST_STATE_EN
  logic [K-2:0]      best_s;
`endif

  // Source metrics for this step: the initial trellis on start, else the stored ones.
  always_comb begin
    for (int s = 0; s < N; s++) begin
      if (start) begin
        cur_pm_s[s] = {PM_W{1'b0}};
        cur_sv_s[s] = (s == 0);
      end else begin
        cur_pm_s[s] = path_metric[s*PM_W +: PM_W];
        cur_sv_s[s] = state_valid[s];
      end
    end
  end

  // Per-state add-compare-select; a tie or a lone p0 keeps the p0 survivor.
  always_comb begin
    for (int s = 0; s < N; s++) begin
      c0_s[s]     = sat_add(cur_pm_s[(2*s) % N],   bm[(2*s)*BM_W +: BM_W]);
      c1_s[s]     = sat_add(cur_pm_s[(2*s+1) % N], bm[(2*s+1)*BM_W +: BM_W]);
      new_sv_s[s] = cur_sv_s[(2*s) % N] | cur_sv_s[(2*s+1) % N];
      if (cur_sv_s[(2*s) % N] && cur_sv_s[(2*s+1) % N]) begin
        dec_s[s] = (c0_s[s] > c1_s[s]);
      end else if (cur_sv_s[(2*s+1) % N]) begin
        dec_s[s] = 1'b1;
      end else begin
        dec_s[s] = 1'b0;
      end
      if (!new_sv_s[s]) begin
        raw_pm_s[s] = {PM_W{1'b0}};
      end else if (dec_s[s]) begin
        raw_pm_s[s] = c1_s[s];
      end else begin
        raw_pm_s[s] = c0_s[s];
      end
    end
  end

  // Minimum over reachable states drives normalisation (and the best-state pick).
  always_comb begin
    min_pm_s  = PM_MAX;
    found_s   = 1'b0;
    take_s    = 1'b0;
    next_pm_s = {(N*PM_W){1'b0}};
`ifdef ACS_BANK_BEST_STATE_EN
    best_s    = {(K-1){1'b0}};
`endif
    for (int s = 0; s < N; s++) begin
      take_s   = new_sv_s[s] && (!found_s || (raw_pm_s[s] < min_pm_s));
      min_pm_s = take_s ? raw_pm_s[s] : min_pm_s;
      found_s  = found_s | take_s;
`ifdef ACS_BANK_BEST_STATE_EN
      best_s   = take_s ? (K-1)'(s) : best_s;
`endif
    end
    norm_s = found_s & min_pm_s[PM_W-1];
    for (int s = 0; s < N; s++) begin
      if (new_sv_s[s] && norm_s) begin
        next_pm_s[s*PM_W +: PM_W] = raw_pm_s[s] - PM_HALF;
      end else begin
        next_pm_s[s*PM_W +: PM_W] = raw_pm_s[s];
      end
    end
  end

  // Output registers: step on in_valid, reload initial metrics on a lone start, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      decision    <= {N{1'b0}};
      state_valid <= {N{1'b0}};
      path_metric <= {(N*PM_W){1'b0}};
`ifdef ACS_BANK_BEST_STATE_EN
      best_state  <= {(K-1){1'b0}};
`endif
    end else if (in_valid) begin
      out_valid   <= 1'b1;
      decision    <= dec_s;
      state_valid <= new_sv_s;
      path_metric <= next_pm_s;
`ifdef ACS_BANK_BEST_STATE_EN
      best_state  <= best_s;
`endif
    end else if (start) begin
      out_valid   <= 1'b0;
      decision    <= {N{1'b0}};
      state_valid <= {{(N-1){1'b0}}, 1'b1};
      path_metric <= {(N*PM_W){1'b0}};
`ifdef ACS_BANK_BEST_STATE_EN
      best_state  <= {(K-1){1'b0}};
`endif
    end else begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_acs_bank.sv
// Self-checking bench for acs_bank: an 8-bit-metric instance plus a 3-bit-metric
// instance (same stimulus) so that saturation is reachable, both against a reference model.
module tb_acs_bank;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        start = 1'b0;
  logic [15:0] bm = 16'h0000;
  logic        ov_a, ov_b;
  logic [3:0]  dec_a, dec_b, sv_a, sv_b;
  logic [31:0] pm_a;
  logic [11:0] pm_b;
`ifdef ACS_BANK_BEST_STATE_EN
  logic [1:0]  best_a, best_b;
`endif

  int checks = 0;
  int passed = 0;
  int sat_seen = 0;
  int pmw_of [2] = '{8, 3};
  int mpm [2][4];
  bit msv [2][4];
  bit mdec [2][4];
  int mbest [2];
  bit mov;

  always #5 clk = ~clk;

  acs_bank #(.K(3), .BM_W(2), .PM_W(8)) u_main (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .start(start), .bm(bm),
    .out_valid(ov_a), .decision(dec_a), .state_valid(sv_a), .path_metric(pm_a)
`ifdef ACS_BANK_BEST_STATE_EN
    , .best_state(best_a)
`endif
  );

  acs_bank #(.K(3), .BM_W(2), .PM_W(3)) u_small (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .start(start), .bm(bm),
    .out_valid(ov_b), .decision(dec_b), .state_valid(sv_b), .path_metric(pm_b)
`ifdef ACS_BANK_BEST_STATE_EN
    , .best_state(best_b)
`endif
  );

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 4; j++) begin
        mpm[i][j] = 0; msv[i][j] = 1'b0; mdec[i][j] = 1'b0;
      end
      mbest[i] = 0;
    end
    mov = 1'b0;
  endtask

  // Trellis step from the rules: cheapest reachable predecessor wins, ties go to p0.
  task automatic model_step(input int i, input bit st, input bit iv, input logic [15:0] b);
    int cp [4];
    bit cv [4];
    int nm [4];
    bit nv [4];
    int mx, mn, best;
    mx = (1 << pmw_of[i]) - 1;
    mov = iv;
    if (!iv) begin
      if (st) begin
        for (int j = 0; j < 4; j++) begin
          mpm[i][j] = 0; msv[i][j] = (j == 0); mdec[i][j] = 1'b0;
        end
        mbest[i] = 0;
      end
      return;
    end
    for (int j = 0; j < 4; j++) begin
      cp[j] = st ? 0 : mpm[i][j];
      cv[j] = st ? (j == 0) : msv[i][j];
    end
    mn = mx + 1;
    best = 0;
    for (int s = 0; s < 4; s++) begin
      int a = (2 * s) % 4;
      int c = (2 * s + 1) % 4;
      int x0 = cp[a] + int'(b[(2*s)*2 +: 2]);
      int x1 = cp[c] + int'(b[(2*s+1)*2 +: 2]);
      if (x0 > mx) begin x0 = mx; sat_seen++; end
      if (x1 > mx) begin x1 = mx; sat_seen++; end
      mdec[i][s] = cv[c] && (!cv[a] || x1 < x0);
      nv[s] = cv[a] || cv[c];
      nm[s] = !nv[s] ? 0 : (mdec[i][s] ? x1 : x0);
      if (nv[s] && nm[s] < mn) begin mn = nm[s]; best = s; end
    end
    for (int s = 0; s < 4; s++) begin
      if (nv[s] && mn <= mx && mn >= (1 << (pmw_of[i] - 1))) nm[s] -= (1 << (pmw_of[i] - 1));
      mpm[i][s] = nm[s];
      msv[i][s] = nv[s];
    end
    mbest[i] = best;
  endtask

  function automatic logic [31:0] epm(input int i);
    logic [31:0] v = 32'h0;
    for (int j = 0; j < 4; j++) v |= 32'(mpm[i][j]) << (j * pmw_of[i]);
    return v;
  endfunction

  function automatic logic [3:0] esv(input int i);
    logic [3:0] v = 4'h0;
    for (int j = 0; j < 4; j++) v[j] = msv[i][j];
    return v;
  endfunction

  function automatic logic [3:0] edec(input int i);
    logic [3:0] v = 4'h0;
    for (int j = 0; j < 4; j++) v[j] = mdec[i][j];
    return v;
  endfunction

  // Drive one cycle of inputs (called just after a falling edge), then advance the model.
  task automatic step(input bit st, input bit iv, input logic [15:0] b);
    start = st; in_valid = iv; bm = b;
    @(negedge clk);
    model_step(0, st, iv, b);
    model_step(1, st, iv, b);
  endtask

  task automatic test_reset();
    checks++; if (ov_a !== 1'b0) $display("FAIL reset_ov: got %b want 0", ov_a); else passed++;
    checks++; if (pm_a !== 32'h0) $display("FAIL reset_pm: got %h want 0", pm_a); else passed++;
    checks++; if ({sv_a, dec_a, sv_b, dec_b} !== 16'h0)
      $display("FAIL reset_sv_dec: got %h want 0", {sv_a, dec_a, sv_b, dec_b}); else passed++;
`ifdef ACS_BANK_BEST_STATE_EN
    checks++; if (best_a !== 2'd0) $display("FAIL reset_best: got %0d want 0", best_a); else passed++;
`endif
  endtask

  task automatic test_no_start();
    step(1'b0, 1'b1, 16'($urandom));
    checks++; if (ov_a !== 1'b1) $display("FAIL nostart_ov: got %b want 1", ov_a); else passed++;
    checks++; if ({pm_a, sv_a, dec_a} !== 40'h0)
      $display("FAIL nostart_out: got %h want 0", {pm_a, sv_a, dec_a}); else passed++;
  endtask

  task automatic test_start_step();
    step(1'b1, 1'b1, 16'h5555);
    checks++; if (ov_a !== 1'b1) $display("FAIL start_ov: got %b want 1", ov_a); else passed++;
    checks++; if (sv_a !== 4'b0101) $display("FAIL start_sv: got %b want 0101", sv_a); else passed++;
    checks++; if (pm_a !== 32'h0001_0001) $display("FAIL start_pm: got %h want 00010001", pm_a); else passed++;
    checks++; if (dec_a !== 4'b0000) $display("FAIL start_dec: got %b want 0000", dec_a); else passed++;
    checks++; if (pm_a !== epm(0)) $display("FAIL start_model: got %h want %h", pm_a, epm(0)); else passed++;
`ifdef ACS_BANK_BEST_STATE_EN
    checks++; if (best_a !== 2'd0) $display("FAIL start_best: got %0d want 0", best_a); else passed++;
`endif
  endtask

  task automatic test_tie();
    step(1'b1, 1'b1, 16'h0203);
    step(1'b0, 1'b1, 16'h0022);
    checks++; if (pm_a !== 32'h0203_0405) $display("FAIL tie_setup: got %h want 02030405", pm_a); else passed++;
    step(1'b0, 1'b1, 16'h0009);
    checks++; if (dec_a[0] !== 1'b0) $display("FAIL tie_dec: got %b want 0", dec_a[0]); else passed++;
    checks++; if (pm_a[7:0] !== 8'd6) $display("FAIL tie_pm: got %0d want 6", pm_a[7:0]); else passed++;
    checks++; if ({sv_a, dec_a, pm_a} !== {esv(0), edec(0), epm(0)})
      $display("FAIL tie_model: got %h want %h", {sv_a, dec_a, pm_a}, {esv(0), edec(0), epm(0)}); else passed++;
  endtask

  task automatic test_normalise();
    int mn, guard, bstep, dmin;
    logic [1:0] b2;
    mn = 0;
    guard = 0;
    do begin
      mn = 256;
      for (int j = 0; j < 4; j++) if (msv[0][j] && mpm[0][j] < mn) mn = mpm[0][j];
      if (mn < 127) begin
        bstep = (127 - mn > 3) ? 3 : 127 - mn;
        b2 = 2'(bstep);
        step(1'b0, 1'b1, {8{b2}});
      end
      guard++;
    end while (mn < 127 && guard < 200);
    checks++; if (mn !== 127 || sv_a !== 4'hF)
      $display("FAIL norm_setup: got min %0d valid %b want 127 1111", mn, sv_a); else passed++;
    checks++; if (pm_a !== epm(0)) $display("FAIL norm_pre: got %h want %h", pm_a, epm(0)); else passed++;
    step(1'b0, 1'b1, 16'h5555);
    dmin = 256;
    for (int j = 0; j < 4; j++) if (int'(pm_a[j*8 +: 8]) < dmin) dmin = int'(pm_a[j*8 +: 8]);
    checks++; if (dmin !== 0) $display("FAIL norm_min: got %0d want 0", dmin); else passed++;
    checks++; if (pm_a !== epm(0)) $display("FAIL norm_pm: got %h want %h", pm_a, epm(0)); else passed++;
  endtask

  task automatic test_idle_late_start();
    logic [31:0] held;
    held = pm_a;
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 1'b0, 16'($urandom));
      checks++; if (ov_a !== 1'b0) $display("FAIL idle_ov: got %b want 0", ov_a); else passed++;
      checks++; if (pm_a !== held || pm_a !== epm(0))
        $display("FAIL idle_hold: got %h want %h", pm_a, held); else passed++;
    end
    step(1'b1, 1'b0, 16'($urandom));
    checks++; if (ov_a !== 1'b0) $display("FAIL late_start_ov: got %b want 0", ov_a); else passed++;
    checks++; if ({pm_a, sv_a, dec_a} !== {32'h0, 4'b0001, 4'b0000})
      $display("FAIL late_start_out: got %h want %h", {pm_a, sv_a, dec_a}, {32'h0, 4'b0001, 4'b0000}); else passed++;
  endtask

  task automatic test_random();
    bit st, iv;
    for (int n = 0; n < 400; n++) begin
      st = (n == 0) || ($urandom_range(0, 15) == 0);
      iv = ($urandom_range(0, 3) != 0);
      step(st, iv, 16'($urandom));
      checks++; if ({ov_a, sv_a, dec_a, pm_a} !== {mov, esv(0), edec(0), epm(0)})
        $display("FAIL rand_main n=%0d: got %h want %h", n, {ov_a, sv_a, dec_a, pm_a}, {mov, esv(0), edec(0), epm(0)});
      else passed++;
      checks++; if ({ov_b, sv_b, dec_b, 20'h0, pm_b} !== {mov, esv(1), edec(1), epm(1)})
        $display("FAIL rand_small n=%0d: got %h want %h", n, {ov_b, sv_b, dec_b, 20'h0, pm_b}, {mov, esv(1), edec(1), epm(1)});
      else passed++;
`ifdef ACS_BANK_BEST_STATE_EN
      checks++; if ({best_a, best_b} !== {2'(mbest[0]), 2'(mbest[1])})
        $display("FAIL rand_best n=%0d: got %h want %h", n, {best_a, best_b}, {2'(mbest[0]), 2'(mbest[1])});
      else passed++;
`endif
    end
    checks++; if (sat_seen == 0) $display("FAIL rand_sat_cover: got 0 saturations want >0"); else passed++;
  endtask

  task automatic test_async_reset();
    step(1'b1, 1'b1, 16'hFFFF);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({ov_a, sv_a, dec_a, pm_a, ov_b, sv_b, dec_b, pm_b} !== 54'h0)
      $display("FAIL async_reset: got %h want 0", {ov_a, sv_a, dec_a, pm_a, ov_b, sv_b, dec_b, pm_b}); else passed++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b1, 16'($urandom));
    checks++; if ({ov_a, sv_a, dec_a, pm_a} !== {1'b1, 40'h0})
      $display("FAIL post_reset_step: got %h want %h", {ov_a, sv_a, dec_a, pm_a}, {1'b1, 40'h0}); else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #1 test_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_no_start();
    test_start_step();
    test_tie();
    test_normalise();
    test_idle_late_start();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/acs_bank.md
ACS_BANK -- requirements
Module: acs_bank

Interface
REQ-001 Parameter K, default 3, constraint length; number of states N = 2^(K-1).
REQ-002 Parameter BM_W, default 2, branch-metric width.
REQ-003 Parameter PM_W, default 8, path-metric width.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  branch metrics valid; one trellis step per cycle when high.
REQ-007 start  input  1  frame start; re-initialise path metrics.
REQ-008 bm  input  N*2*BM_W  branch metrics; field [s*2+j] is the metric of branch j into state s.
REQ-009 out_valid  output  1  registered outputs reflect a completed step.
REQ-010 decision  output  N  survivor select per state; bit s = 1 means predecessor p1 won.
REQ-011 state_valid  output  N  per-state reachability.
REQ-012 path_metric  output  N*PM_W  registered path metric per state.
REQ-013 best_state  output  K-1  lowest-metric state index (present only when ACS_BANK_BEST_STATE_EN is defined).

Function
REQ-014 Predecessors of state s: p0 = (2s) mod N, p1 = (2s+1) mod N.
REQ-015 Candidate cost cj = pm[pj] + bm[s][j], computed in PM_W+1 bits, saturated to 2^PM_W-1 on overflow.
REQ-016 Candidate j is valid iff state_valid[pj] is set.
REQ-017 Selection: only p0 valid -> 0; only p1 valid -> 1; both valid -> 1 iff c0 > c1 (tie selects 0); neither valid -> 0.
REQ-018 New state_valid[s] = valid(c0) OR valid(c1); metric of an invalid state is 0.
REQ-019 Normalisation: if the minimum over valid new metrics has bit PM_W-1 set, 2^(PM_W-1) is subtracted from every valid new metric in the same step.
REQ-020 On a cycle with in_valid=1, path_metric, state_valid and decision update at the next edge and out_valid is 1 for exactly that cycle (latency 1, throughput 1 step/cycle).
REQ-021 On a cycle with in_valid=0, path_metric, state_valid and decision hold and out_valid is 0.
REQ-022 start=1 with in_valid=1: the step uses initial metrics (state 0 valid, metric 0; all others invalid) in place of the stored ones.
REQ-023 start=1 with in_valid=0: stored metrics load the initial values, decision goes to 0 and out_valid is 0.
REQ-024 No back-pressure; the bank accepts every in_valid cycle.

Reset
REQ-025 While rst_n=0: out_valid=0, decision=0, state_valid=0, path_metric=0 and best_state=0, asynchronously.
REQ-026 After reset and before the first start, the first step sees every predecessor invalid, so all outputs stay 0 with out_valid=1.
REQ-027 Reset asserted mid-frame discards all metrics; recovery requires start.

Configuration
REQ-028 With ACS_BANK_BEST_STATE_EN defined: best_state is a registered output updated with path_metric, equal to the lowest-index valid state of minimum new metric, and 0 if no state is valid.
REQ-029 Without ACS_BANK_BEST_STATE_EN: the best_state port and its comparator tree are absent; all other behaviour is identical.

Verification (K=3, BM_W=2, PM_W=8)
REQ-030 Async reset scenario: rst_n low mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.
REQ-031 Start step scenario: start=1, in_valid=1, all bm=1.
  -> Next cycle: out_valid=1, state_valid=0101, metrics {0:1, 1:0, 2:1, 3:0}, decision=0000, best_state=0.
REQ-032 Tie scenario: stored metrics {0:5, 1:4} with bm[0][0]=1 and bm[0][1]=2 (both candidates 6).
  -> decision[0]=0, path_metric[0]=6.
REQ-033 Normalisation scenario: all states valid, stored min 127, every bm=1.
  -> New metrics have min 128, so every stored metric is reduced by 128 (min becomes 0).
REQ-034 Saturation scenario: pm[0]=254, bm[0][0]=3, p1 invalid.
  -> Candidate clamps to 255 and decision[0]=0.
REQ-035 Idle and late-start scenario: in_valid low for 3 cycles -> outputs hold and out_valid=0; then start alone -> metrics reload to initial values and out_valid=0.
